// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MEM stage of the 5-stage MIPS pipeline. Runs loads and stores
//             over a req/ack data bus, stalls the upstream pipeline while an
//             access is outstanding and holds the MEM/WB pipeline register.
//  Options  : `define MEM_STAGE_ALIGN_CHECK_EN to reject word accesses whose
//             address bits [1:0] are non-zero (no bus cycle, error flagged).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    // EX/MEM register
    input  logic        reg_write_m,
    input  logic        mem_to_reg_m,
    input  logic        mem_write_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] write_data_m,
    input  logic [4:0]  write_reg_m,
    input  logic        upper_m,
    input  logic        syscall_m,
    output logic        stall_m,
    // data bus
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    // MEM/WB register
    output logic        reg_write_w,
    output logic        mem_to_reg_w,
    output logic [31:0] read_data_w,
    output logic [31:0] alu_result_w,
    output logic [4:0]  write_reg_w,
    output logic        upper_w,
    output logic        syscall_w,
    output logic        bus_err_w
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Count value at which a BUSY access without ack is abandoned
    localparam logic [7:0] c_last_count = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_count;
    logic        r_err;
    logic        r_misalign;
    logic [31:0] r_rdata;

    logic        w_access;
    logic        w_misalign;
    logic        w_timeout;
    logic        w_capture;
    logic        w_in_done;

    assign w_access  = mem_to_reg_m | mem_write_m;
    assign w_timeout = (r_count == c_last_count);
    assign w_in_done = (r_state == DONE);

    // The MEM/WB register takes real data only when the instruction in
    // EX/MEM is complete; every other cycle it receives a bubble.
    assign w_capture = ((r_state == IDLE) && !w_access) || w_in_done;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign w_misalign = w_access && (alu_result_m[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and stall decode; stall is released in DONE so EX/MEM
    // advances on the same edge that retires the access into MEM/WB.
    always_comb begin
        w_next  = r_state;
        stall_m = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    stall_m = 1'b1;
                    w_next  = w_misalign ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall_m = 1'b1;
                if (bus_ack || w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Bus request, timeout counter, captured read data and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            r_count    <= 8'd0;
            r_err      <= 1'b0;
            r_misalign <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        r_count    <= 8'd0;
                        r_err      <= w_misalign;
                        r_misalign <= w_misalign;
                        r_rdata    <= 32'd0;
                        if (!w_misalign) begin
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write_m;
                            bus_addr  <= {alu_result_m[31:2], 2'b00};
                            bus_wdata <= write_data_m;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            r_rdata <= bus_rdata;
                        end
                    end else if (w_timeout) begin
                        bus_req <= 1'b0;
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // MEM/WB pipeline register: real instruction or bubble
    always_ff @(posedge clk) begin
        if (rst || !w_capture) begin
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            read_data_w  <= 32'd0;
            alu_result_w <= 32'd0;
            write_reg_w  <= 5'd0;
            upper_w      <= 1'b0;
            syscall_w    <= 1'b0;
            bus_err_w    <= 1'b0;
        end else begin
            reg_write_w  <= reg_write_m & ~(w_in_done & r_misalign);
            mem_to_reg_w <= mem_to_reg_m;
            read_data_w  <= w_in_done ? r_rdata : 32'd0;
            alu_result_w <= alu_result_m;
            write_reg_w  <= write_reg_m;
            upper_w      <= upper_m;
            syscall_w    <= syscall_m;
            bus_err_w    <= w_in_done & r_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Directed self-checking bench for mem_stage. Each instruction is
//             expanded into its expected cycle timeline (stall, bus request,
//             MEM/WB contents); a negedge compare process checks the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_m, mem_to_reg_m, mem_write_m, upper_m, syscall_m;
    logic [31:0] alu_result_m, write_data_m;
    logic [4:0]  write_reg_m;
    logic        stall_m, bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        reg_write_w, mem_to_reg_w, upper_w, syscall_w, bus_err_w;
    logic [31:0] read_data_w, alu_result_w;
    logic [4:0]  write_reg_w;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
        .mem_write_m(mem_write_m), .alu_result_m(alu_result_m),
        .write_data_m(write_data_m), .write_reg_m(write_reg_m),
        .upper_m(upper_m), .syscall_m(syscall_m), .stall_m(stall_m),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w),
        .read_data_w(read_data_w), .alu_result_w(alu_result_w),
        .write_reg_w(write_reg_w), .upper_w(upper_w),
        .syscall_w(syscall_w), .bus_err_w(bus_err_w)
    );

    int vectors     = 0;
    int miscompares = 0;
    int n_stall     = 0;
    int n_req       = 0;
    logic check_en  = 1'b0;

    // Expected values for the current cycle
    logic        e_stall, e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_rw, e_m2r, e_up, e_sc, e_err;
    logic [31:0] e_rd, e_alu;
    logic [4:0]  e_wreg;
    int          e_mode;   // 0: full MEM/WB, 1: bubble, 2: rejected access

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_wb(input int mode, input logic rw, m2r, input logic [31:0] rd, alu,
                          input logic [4:0] wr, input logic up, sc, err);
        e_mode = mode; e_rw = rw; e_m2r = m2r; e_rd = rd; e_alu = alu;
        e_wreg = wr; e_up = up; e_sc = sc; e_err = err;
    endtask

    task automatic set_bubble();
        set_wb(1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One compare process for every cycle once reset has been applied
    always @(negedge clk) begin
        if (check_en) begin
            chk("stall_m", 32'(stall_m), 32'(e_stall));
            chk("bus_req", 32'(bus_req), 32'(e_req));
            if (e_req) begin
                chk("bus_we", 32'(bus_we), 32'(e_we));
                chk("bus_addr", bus_addr, e_addr);
                chk("bus_wdata", bus_wdata, e_wdata);
            end
            chk("reg_write_w", 32'(reg_write_w), 32'(e_rw));
            if (e_mode != 2) chk("syscall_w", 32'(syscall_w), 32'(e_sc));
            if (e_mode != 1) chk("bus_err_w", 32'(bus_err_w), 32'(e_err));
            if (e_mode == 0) begin
                chk("mem_to_reg_w", 32'(mem_to_reg_w), 32'(e_m2r));
                chk("read_data_w", read_data_w, e_rd);
                chk("alu_result_w", alu_result_w, e_alu);
                chk("write_reg_w", 32'(write_reg_w), 32'(e_wreg));
                chk("upper_w", 32'(upper_w), 32'(e_up));
            end
        end
    end

    // Let one cycle elapse (checked at negedge), land just after the next edge
    task automatic cycle();
        @(negedge clk);
        if (stall_m) n_stall++;
        if (bus_req) n_req++;
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in EX/MEM and walk its expected timeline.
    // ack_after = BUSY cycle in which bus_ack is given (0 = never).
    task automatic run_instr(input logic rw, m2r, mw, input logic [31:0] alu, wd,
                             input logic [4:0] wr, input logic up, sc,
                             input int ack_after, input logic [31:0] rdata, input logic stray);
        logic acc, mis, acked;
        acc   = m2r | mw;
        acked = 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        mis = acc && (alu[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        n_stall = 0; n_req = 0;
        reg_write_m = rw; mem_to_reg_m = m2r; mem_write_m = mw; alu_result_m = alu;
        write_data_m = wd; write_reg_m = wr; upper_m = up; syscall_m = sc;
        bus_rdata = rdata;
        if (!acc) begin
            bus_ack = stray;                 // must be ignored outside BUSY
            e_stall = 1'b0; e_req = 1'b0;
            cycle();
            set_wb(0, rw, m2r, 32'd0, alu, wr, up, sc, 1'b0);
        end else begin
            bus_ack = 1'b0;
            e_stall = 1'b1; e_req = 1'b0;
            cycle();
            set_bubble();
            if (mis) begin
                e_stall = 1'b0; e_req = 1'b0;
                cycle();
                set_wb(2, 1'b0, m2r, 32'd0, alu, wr, up, sc, 1'b1);
            end else begin
                for (int i = 1; i <= TO && !acked; i++) begin
                    e_stall = 1'b1; e_req = 1'b1; e_we = mw;
                    e_addr = {alu[31:2], 2'b00}; e_wdata = wd;
                    bus_ack = (i == ack_after);
                    acked   = (i == ack_after);
                    cycle();
                    set_bubble();
                end
                bus_ack = 1'b0;
                e_stall = 1'b0; e_req = 1'b0;
                cycle();
                set_wb(0, rw, m2r, (acked && !mw) ? rdata : 32'd0, alu, wr, up, sc, !acked);
            end
        end
        bus_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0;
        reg_write_m = 0; mem_to_reg_m = 0; mem_write_m = 0; upper_m = 0; syscall_m = 0;
        alu_result_m = 0; write_data_m = 0; write_reg_m = 0;
        e_stall = 0; e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
        set_wb(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check_en = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();

        // ALU op with a stray ack in IDLE
        run_instr(1, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 0, 32'hDEAD_BEEF, 1);
        chk("lit_alu_rw", 32'(reg_write_w), 32'd1);
        chk("lit_alu_res", alu_result_w, 32'h0000_1234);
        chk("lit_alu_wreg", 32'(write_reg_w), 32'd5);
        chk("lit_alu_stall", 32'(n_stall), 32'd0);

        // Zero-wait load
        run_instr(1, 1, 0, 32'h0000_0100, 32'h0, 5'd8, 0, 0, 1, 32'hCAFE_F00D, 0);
        chk("lit_ld_stall", 32'(n_stall), 32'd2);
        chk("lit_ld_req", 32'(n_req), 32'd1);
        chk("lit_ld_rdata", read_data_w, 32'hCAFE_F00D);
        chk("lit_ld_m2r", 32'(mem_to_reg_w), 32'd1);

        // Store acked in the 4th BUSY cycle
        run_instr(0, 0, 1, 32'h0000_0200, 32'h55AA_55AA, 5'd0, 0, 0, 4, 32'h0, 0);
        chk("lit_st_req", 32'(n_req), 32'd4);
        chk("lit_st_stall", 32'(n_stall), 32'd5);

        // Load that times out
        run_instr(1, 1, 0, 32'h0000_0300, 32'h0, 5'd3, 0, 0, 0, 32'h7777_7777, 0);
        chk("lit_to_req", 32'(n_req), 32'd4);
        chk("lit_to_err", 32'(bus_err_w), 32'd1);
        chk("lit_to_rdata", read_data_w, 32'd0);

        // Load+store both set: store wins
        run_instr(1, 1, 1, 32'h0000_0404, 32'hA5A5_0F0F, 5'd12, 0, 0, 2, 32'h1111_1111, 0);
        // Misaligned load
        run_instr(1, 1, 0, 32'h0000_0102, 32'h0, 5'd7, 0, 0, 1, 32'h1234_5678, 0);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        chk("lit_mis_req", 32'(n_req), 32'd0);
        chk("lit_mis_stall", 32'(n_stall), 32'd1);
        chk("lit_mis_err", 32'(bus_err_w), 32'd1);
`else
        chk("lit_mis_rdata", read_data_w, 32'h1234_5678);
`endif
        // Back-to-back pass-through ops
        run_instr(1, 0, 0, 32'hFFFF_0000, 32'h0, 5'd31, 1, 0, 0, 32'h0, 0);
        run_instr(0, 0, 0, 32'h0000_0042, 32'h0, 5'd2, 0, 1, 0, 32'h0, 0);

        // Reset in the middle of a BUSY access, then a late ack
        reg_write_m = 1; mem_to_reg_m = 1; mem_write_m = 0; alu_result_m = 32'h500;
        write_reg_m = 5'd9; upper_m = 0; syscall_m = 0; bus_ack = 0;
        e_stall = 1; e_req = 0;
        cycle();
        set_bubble();
        e_stall = 1; e_req = 1; e_we = 0; e_addr = 32'h500; e_wdata = write_data_m;
        cycle();
        rst = 1'b1;
        cycle();
        set_wb(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        reg_write_m = 0; mem_to_reg_m = 0; alu_result_m = 0; write_reg_m = 0;
        bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        e_stall = 0; e_req = 0;
        chk("lit_rst_req", 32'(bus_req), 32'd0);
        chk("lit_rst_rw", 32'(reg_write_w), 32'd0);
        cycle();
        bus_ack = 1'b0;
        cycle();

        // Normal operation resumes
        run_instr(1, 1, 0, 32'h0000_0800, 32'h0, 5'd4, 0, 0, 3, 32'h0BAD_CAFE, 0);
        run_instr(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0, 0);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
